w_icons_stim_seq: RTL and testbench
===================================

# w_icons_stim_seq

Biphasic stimulation pulse sequencer for the W_ICONS management domain. It runs on `clk_ref_i` and, once armed by a start strobe, drives the enable inputs of the stimulation clock divider and the discharge clock divider. It steps through cathodic phase, interphase gap, anodic phase, electrode discharge and inter-pulse interval for a programmed pulse count. It aborts into a safety discharge whenever the synchronized stim error asserts or the synchronized stim enable drops.

## Interface
Parameters:
- `LEN_W`, 12, width of every phase-length field (cycles of `clk_ref_i`)
- `NPULSE_W`, 8, width of pulse-count field and counter

Ports:
- `clk_ref_i`  in  1  reference clock; sole clock
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  single-cycle start strobe (already in `clk_ref_i` domain)
- `stim_xen_sync_i`  in  1  synchronized stim enable; low blocks/aborts
- `err_stim_sync_i`  in  1  synchronized stim error; high aborts
- `n_pulses_i`  in  NPULSE_W  pulses per burst; 0 = start ignored
- `ph1_len_i`, `gap_len_i`, `ph2_len_i`, `dis_len_i`, `ipi_len_i`  in  LEN_W each  state durations
- `en_clk_stim_o`  out  1  enable to stim clock divider
- `en_clk_discharge_o`  out  1  enable to discharge clock divider
- `phase_o`  out  2  01 cathodic (PH1), 10 anodic (PH2), 00 otherwise
- `busy_o`  out  1  sequence active (any state except IDLE)
- `done_o`  out  1  one-cycle pulse on normal completion
- `abort_o`  out  1  one-cycle pulse on abort completion
- `pulse_cnt_o`  out  NPULSE_W  completed pulses in current/last burst

## Operation
- States: IDLE, PH1, GAP, PH2, DIS, IPI, ABRT.
- IDLE exits to PH1 on `start_i & stim_xen_sync_i & ~err_stim_sync_i & (n_pulses_i != 0)`. All length fields and `n_pulses_i` are latched on that edge. Later input changes have no effect until the next start. `pulse_cnt_o` clears to 0 on accepted start.
- Length semantics: a state lasts exactly L cycles. L = 0 is treated as 1 cycle; no state is ever skipped.
- Transitions: PH1→GAP→PH2→DIS. `pulse_cnt_o` increments on PH2 exit.
- DIS exits to IPI if pulses remain, otherwise to IDLE with `done_o`. IPI exits to PH1.
- Abort: in PH1/GAP/PH2/DIS/IPI, `err_stim_sync_i` high or `stim_xen_sync_i` low moves the block to ABRT on the next edge. This takes priority over the normal transition in the same cycle.
- ABRT lasts latched `dis_len` cycles, then goes to IDLE with `abort_o`. Abort conditions during ABRT are ignored.
- Output decode (registered, valid in the cycle the state is occupied):
  - `en_clk_stim_o` = PH1|GAP|PH2
  - `en_clk_discharge_o` = DIS|ABRT
  - `busy_o` = state≠IDLE
- `start_i` outside IDLE is ignored.
- Single down-counter: loaded with (L==0 ? 0 : L-1) on state entry; state exits when the counter reaches 0.

## Timing
- Reset (synchronous): state IDLE, counters 0, all outputs 0 on the first edge with `reset_i` high. Reset mid-sequence drops both enables on that edge; no discharge is performed.
- Start latency: `start_i` at cycle 0 puts PH1 in cycle 1, with `en_clk_stim_o` and `phase_o`=01 high from cycle 1.
- Abort latency: condition sampled at cycle k gives ABRT in cycle k+1. `en_clk_stim_o` falls and `en_clk_discharge_o` rises in the same cycle.
- `done_o`/`abort_o` are high in the first IDLE cycle after completion, for one cycle, with `busy_o` already 0. A new start is accepted in that same cycle.
- Simultaneous start and abort condition in IDLE: start is rejected.
- Counter and pulse arithmetic is unsigned; `pulse_cnt_o` never wraps because it is bounded by `n_pulses`.

## Test plan
- Nominal burst: n=2, ph1=3, gap=2, ph2=3, dis=4, ipi=5, start at cycle 0. Required response:
  - PH1 1–3, GAP 4–5, PH2 6–8, DIS 9–12, IPI 13–17, PH1 18–20, GAP 21–22, PH2 23–25, DIS 26–29.
  - `done_o`=1 at cycle 30 only; `pulse_cnt_o`=2.
- Zero lengths: n=1, all lengths 0 → PH1, GAP, PH2, DIS one cycle each (cycles 1–4); `done_o` at cycle 5.
- Error abort: nominal config, `err_stim_sync_i` pulsed at cycle 7 (PH2). Required response:
  - ABRT cycles 8–11, `en_clk_stim_o` 0 from cycle 8.
  - `abort_o` at cycle 12; `pulse_cnt_o`=0; `done_o` never asserts.
- Enable gating: `stim_xen_sync_i`=0 with start → stays IDLE. n_pulses=0 with start → stays IDLE. Start during busy → no restart, timeline unchanged.
- Reset mid-burst: `reset_i` at cycle 10 → all outputs 0 at cycle 11. Start at cycle 12 → PH1 at cycle 13 with freshly latched config.
- Config change during burst: change ph1_len from 3 to 9 at cycle 5 → second pulse PH1 still 3 cycles.

Source files
------------

// File: rtl/w_icons_stim_seq.sv
// Biphasic stimulation pulse sequencer: steps PH1/GAP/PH2/DIS/IPI for a programmed
// pulse count and falls back to a timed safety discharge whenever stimulation is lost.
module w_icons_stim_seq #(
    parameter int LEN_W    = 12,
    parameter int NPULSE_W = 8
) (
    input  logic                clk_ref_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                stim_xen_sync_i,
    input  logic                err_stim_sync_i,
    input  logic [NPULSE_W-1:0] n_pulses_i,
    input  logic [LEN_W-1:0]    ph1_len_i,
    input  logic [LEN_W-1:0]    gap_len_i,
    input  logic [LEN_W-1:0]    ph2_len_i,
    input  logic [LEN_W-1:0]    dis_len_i,
    input  logic [LEN_W-1:0]    ipi_len_i,
    output logic                en_clk_stim_o,
    output logic                en_clk_discharge_o,
    output logic [1:0]          phase_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                abort_o,
    output logic [NPULSE_W-1:0] pulse_cnt_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        GAP  = 3'd2,
        PH2  = 3'd3,
        DIS  = 3'd4,
        IPI  = 3'd5,
        ABRT = 3'd6
    } state_t;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    cnt, cnt_nxt;
    logic [LEN_W-1:0]    ph1_len_q, gap_len_q, ph2_len_q, dis_len_q, ipi_len_q;
    logic [NPULSE_W-1:0] n_pulses_q;
    logic                accept, pulse_inc, done_nxt, abort_nxt, abort_cond;

    // A length of 0 still occupies one cycle, so it loads the same value as 1.
    function automatic logic [LEN_W-1:0] len_load(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - LEN_W'(1);
    endfunction

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        pulse_inc  = 1'b0;
        done_nxt   = 1'b0;
        abort_nxt  = 1'b0;
        abort_cond = err_stim_sync_i | ~stim_xen_sync_i;
        case (state)
            IDLE: begin
                if (start_i && !abort_cond && (n_pulses_i != '0)) begin
                    state_nxt = PH1;
                    cnt_nxt   = len_load(ph1_len_i);
                    accept    = 1'b1;
                end
            end
            ABRT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - LEN_W'(1);
                end else begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                end
            end
            PH1, GAP, PH2, DIS, IPI: begin
                // Loss of stimulation wins over the normal phase timeout.
                if (abort_cond) begin
                    state_nxt = ABRT;
                    cnt_nxt   = len_load(dis_len_q);
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - LEN_W'(1);
                end else begin
                    case (state)
                        PH1: begin
                            state_nxt = GAP;
                            cnt_nxt   = len_load(gap_len_q);
                        end
                        GAP: begin
                            state_nxt = PH2;
                            cnt_nxt   = len_load(ph2_len_q);
                        end
                        PH2: begin
                            state_nxt = DIS;
                            cnt_nxt   = len_load(dis_len_q);
                            pulse_inc = 1'b1;
                        end
                        DIS: begin
                            if (pulse_cnt_o != n_pulses_q) begin
                                state_nxt = IPI;
                                cnt_nxt   = len_load(ipi_len_q);
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                        IPI: begin
                            state_nxt = PH1;
                            cnt_nxt   = len_load(ph1_len_q);
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the occupied state.
    always_ff @(posedge clk_ref_i) begin
        if (reset_i) begin
            state              <= IDLE;
            cnt                <= '0;
            pulse_cnt_o        <= '0;
            en_clk_stim_o      <= 1'b0;
            en_clk_discharge_o <= 1'b0;
            phase_o            <= 2'b00;
            busy_o             <= 1'b0;
            done_o             <= 1'b0;
            abort_o            <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            if (accept) begin
                pulse_cnt_o <= '0;
            end else if (pulse_inc) begin
                pulse_cnt_o <= pulse_cnt_o + NPULSE_W'(1);
            end
            en_clk_stim_o      <= (state_nxt == PH1) || (state_nxt == GAP) || (state_nxt == PH2);
            en_clk_discharge_o <= (state_nxt == DIS) || (state_nxt == ABRT);
            phase_o            <= (state_nxt == PH1) ? 2'b01 :
                                  (state_nxt == PH2) ? 2'b10 : 2'b00;
            busy_o             <= (state_nxt != IDLE);
            done_o             <= done_nxt;
            abort_o            <= abort_nxt;
        end
    end

    // Burst configuration is frozen at start so mid-burst input changes are harmless.
    always_ff @(posedge clk_ref_i) begin
        if (accept) begin
            n_pulses_q <= n_pulses_i;
            ph1_len_q  <= ph1_len_i;
            gap_len_q  <= gap_len_i;
            ph2_len_q  <= ph2_len_i;
            dis_len_q  <= dis_len_i;
            ipi_len_q  <= ipi_len_i;
        end
    end

endmodule

// File: tb/tb_w_icons_stim_seq.sv
// Scoreboard bench for w_icons_stim_seq: the driver queues the hand-derived per-cycle
// output timeline of each directed scenario, a monitor compares it on the falling edge.
module tb_w_icons_stim_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, xen = 1'b1, err = 1'b0;
    logic [7:0]  n = '0;
    logic [11:0] ph1 = '0, gap = '0, ph2 = '0, dis = '0, ipi = '0;
    logic        en_s, en_d, busy, done, abrt;
    logic [1:0]  phase;
    logic [7:0]  pcnt;

    always #5 clk = ~clk;

    w_icons_stim_seq #(.LEN_W(12), .NPULSE_W(8)) dut (
        .clk_ref_i(clk), .reset_i(reset), .start_i(start),
        .stim_xen_sync_i(xen), .err_stim_sync_i(err), .n_pulses_i(n),
        .ph1_len_i(ph1), .gap_len_i(gap), .ph2_len_i(ph2), .dis_len_i(dis), .ipi_len_i(ipi),
        .en_clk_stim_o(en_s), .en_clk_discharge_o(en_d), .phase_o(phase),
        .busy_o(busy), .done_o(done), .abort_o(abrt), .pulse_cnt_o(pcnt)
    );

    typedef struct {
        int          cyc;
        logic [14:0] v;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [14:0] act;
    int         tests = 0, fails = 0, cyc = 0, exp_cyc = 0;
    logic [7:0] exp_pcnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Codes: 0 IDLE, 1 PH1, 2 GAP, 3 PH2, 4 DIS, 5 IPI, 6 ABRT; flag 1 done, 2 abort.
    function automatic logic [14:0] mk(input int code, input int flag, input logic [7:0] pc);
        logic       es, ed, bz;
        logic [1:0] ph;
        es = (code >= 1) && (code <= 3);
        ed = (code == 4) || (code == 6);
        ph = (code == 1) ? 2'b01 : (code == 3) ? 2'b10 : 2'b00;
        bz = (code != 0);
        return {es, ed, ph, bz, flag == 1, flag == 2, pc};
    endfunction

    task automatic seg(input int code, input int len, input int flag);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.cyc = exp_cyc;
            e.v   = mk(code, (i == 0) ? flag : 0, exp_pcnt);
            sb.push_back(e);
            exp_cyc++;
        end
    endtask

    task automatic nom_pulse();
        seg(1, 3, 0); seg(2, 2, 0); seg(3, 3, 0);
        exp_pcnt++;
        seg(4, 4, 0);
    endtask

    task automatic nom_burst();
        nom_pulse(); seg(5, 5, 0); nom_pulse();
        seg(0, 1, 1); seg(0, 2, 0);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int np, input int l1, input int lg, input int l2, input int ld, input int li);
        n = 8'(np); ph1 = 12'(l1); gap = 12'(lg); ph2 = 12'(l2); dis = 12'(ld); ipi = 12'(li);
    endtask

    task automatic go();
        start    = 1'b1;
        exp_cyc  = cyc + 1;
        exp_pcnt = '0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            tests++;
            act = {en_s, en_d, phase, busy, done, abrt, pcnt};
            if (cur.cyc != cyc || act !== cur.v)
            begin
                fails++;
                $display("FAIL outputs cycle %0d: got %h, expected %h (for cycle %0d)",
                         cyc, act, cur.v, cur.cyc);
            end
        end
    end

    initial begin
        // Reset state
        tick(1);
        exp_cyc = cyc; exp_pcnt = '0;
        seg(0, 3, 0);
        reset = 1'b0;
        tick(4);

        // Nominal burst
        cfg(2, 3, 2, 3, 4, 5);
        go(); nom_burst();
        tick(1); start = 1'b0;
        tick(34);

        // Config change and start strobe while busy leave the timeline unchanged
        go(); nom_burst();
        tick(1); start = 1'b0;
        tick(4); ph1 = 12'd9;
        tick(5); start = 1'b1;
        tick(1); start = 1'b0;
        tick(24); ph1 = 12'd3;

        // Zero lengths: each state still lasts one cycle
        cfg(1, 0, 0, 0, 0, 0);
        go();
        seg(1, 1, 0); seg(2, 1, 0); seg(3, 1, 0);
        exp_pcnt++;
        seg(4, 1, 0); seg(0, 1, 1); seg(0, 2, 0);
        tick(1); start = 1'b0;
        tick(10);

        // Error pulse in PH2
        cfg(2, 3, 2, 3, 4, 5);
        go();
        seg(1, 3, 0); seg(2, 2, 0); seg(3, 2, 0); seg(6, 4, 0); seg(0, 1, 2); seg(0, 2, 0);
        tick(1); start = 1'b0;
        tick(6); err = 1'b1;
        tick(1); err = 1'b0;
        tick(10);

        // Enable dropped in IPI and held low into ABRT
        go();
        nom_pulse(); seg(5, 2, 0); seg(6, 4, 0); seg(0, 1, 2); seg(0, 2, 0);
        tick(1); start = 1'b0;
        tick(13); xen = 1'b0;
        tick(3); xen = 1'b1;
        tick(8);

        // Rejected starts: enable low, zero pulse count, simultaneous error
        for (int k = 0; k < 3; k++) begin
            cfg(2, 3, 2, 3, 4, 5);
            start = 1'b1;
            if (k == 0) xen = 1'b0;
            if (k == 1) n = 8'd0;
            if (k == 2) err = 1'b1;
            exp_cyc = cyc + 1;
            seg(0, 3, 0);
            tick(1); start = 1'b0; xen = 1'b1; err = 1'b0;
            tick(3);
        end

        // Reset mid-burst, then restart with a fresh configuration
        cfg(2, 3, 2, 3, 4, 5);
        go();
        seg(1, 3, 0); seg(2, 2, 0); seg(3, 3, 0);
        exp_pcnt++;
        seg(4, 2, 0);
        exp_pcnt = '0;
        seg(0, 2, 0);
        seg(1, 1, 0); seg(2, 1, 0); seg(3, 2, 0);
        exp_pcnt++;
        seg(4, 1, 0); seg(0, 1, 1); seg(0, 2, 0);
        tick(1); start = 1'b0;
        tick(9); reset = 1'b1;
        tick(1); reset = 1'b0; cfg(1, 1, 0, 2, 1, 7);
        tick(1); start = 1'b1;
        tick(1); start = 1'b0;
        tick(10);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
